// File: rtl/conv_sequencer.sv
// Frame-level controller for the convolution datapath: loads taps, streams samples,
// flushes the window with zeros and aligns out_valid/out_last with the datapath latency.
module conv_sequencer #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned WINDOW_SIZE    = 20,
  parameter int unsigned ADDER_STAGES   = $clog2(WINDOW_SIZE),
  parameter int unsigned MULT_LATENCY   = 1,
  parameter int unsigned FRAME_LEN_SIZE = 16,
  localparam int unsigned ADDR_W        = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_start,
  input  logic [FRAME_LEN_SIZE-1:0] cfg_frame_len,
  input  logic                      cfg_abort,
  input  logic                      coef_valid,
  input  logic [DATA_SIZE-1:0]      coef_data,
  output logic                      coef_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      dp_coef_we,
  output logic [ADDR_W-1:0]         dp_coef_addr,
  output logic [DATA_SIZE-1:0]      dp_coef_data,
  output logic                      dp_shift_en,
  output logic                      dp_flush,
  output logic                      out_valid,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned PIPE_LAT   = MULT_LATENCY + ADDER_STAGES;
  localparam bit          NO_FLUSH   = (WINDOW_SIZE == 1);
  localparam int unsigned LAST_COEF  = WINDOW_SIZE - 1;
  localparam int unsigned LAST_FLUSH = (WINDOW_SIZE > 1) ? WINDOW_SIZE - 2 : 0;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DRAIN} state_t;

  state_t                    state, state_next;
  logic [FRAME_LEN_SIZE-1:0] frame_len;
  logic [FRAME_LEN_SIZE-1:0] sample_cnt;
  logic [ADDR_W-1:0]         coef_cnt;
  logic [ADDR_W-1:0]         flush_cnt;
  logic [PIPE_LAT-1:0]       valid_pipe;
  logic [PIPE_LAT-1:0]       last_pipe;
  logic                      last_tag;
  logic                      abort_clr;
  logic                      start_acc;

  assign out_valid = valid_pipe[PIPE_LAT-1];
  assign out_last  = last_pipe[PIPE_LAT-1];
  assign busy      = (state != IDLE);
  assign abort_clr = cfg_abort && (state != IDLE);
  assign start_acc = (state == IDLE) && (state_next == LOAD);

  always_comb begin
    state_next   = state;
    coef_ready   = 1'b0;
    in_ready     = 1'b0;
    dp_coef_we   = 1'b0;
    dp_coef_addr = '0;
    dp_coef_data = '0;
    dp_shift_en  = 1'b0;
    dp_flush     = 1'b0;
    last_tag     = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start && !cfg_abort && (cfg_frame_len != '0)) state_next = LOAD;
      end
      LOAD: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          dp_coef_we   = 1'b1;
          dp_coef_addr = coef_cnt;
          dp_coef_data = coef_data;
          if (coef_cnt == ADDR_W'(LAST_COEF)) state_next = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dp_shift_en = 1'b1;
          if (sample_cnt == frame_len - FRAME_LEN_SIZE'(1)) begin
            if (NO_FLUSH) begin
              last_tag   = 1'b1;
              state_next = DRAIN;
            end else begin
              state_next = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        dp_shift_en = 1'b1;
        dp_flush    = 1'b1;
        if (flush_cnt == ADDR_W'(LAST_FLUSH)) begin
          last_tag   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort_clr) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_len  <= '0;
      sample_cnt <= '0;
      coef_cnt   <= '0;
      flush_cnt  <= '0;
    end else if (abort_clr || start_acc) begin
      frame_len  <= abort_clr ? '0 : cfg_frame_len;
      sample_cnt <= '0;
      coef_cnt   <= '0;
      flush_cnt  <= '0;
    end else begin
      if (dp_coef_we) coef_cnt <= coef_cnt + ADDR_W'(1);
      if (in_ready && in_valid) sample_cnt <= sample_cnt + FRAME_LEN_SIZE'(1);
      if (dp_flush) flush_cnt <= flush_cnt + ADDR_W'(1);
    end
  end

  // Valid/last travel alongside the datapath so the tails line up with its results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else if (abort_clr) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= dp_shift_en;
      last_pipe[0]  <= last_tag;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: expected outputs are queued as shifts are driven
// and popped when their latency expires.
module tb_conv_sequencer;
  localparam int unsigned W   = 20;
  localparam int unsigned LAT = 6;
  localparam int unsigned DS  = 16;
  localparam int unsigned FL  = 16;
  localparam int unsigned AW  = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [FL-1:0] cfg_frame_len = '0;
  logic          cfg_abort = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DS-1:0] coef_data = '0;
  logic          coef_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          dp_coef_we;
  logic [AW-1:0] dp_coef_addr;
  logic [DS-1:0] dp_coef_data;
  logic          dp_shift_en, dp_flush, out_valid, out_last, busy, done;

  conv_sequencer #(
    .DATA_SIZE(DS), .WINDOW_SIZE(W), .ADDER_STAGES(5), .MULT_LATENCY(1), .FRAME_LEN_SIZE(FL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_frame_len(cfg_frame_len),
    .cfg_abort(cfg_abort), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_ready(coef_ready), .in_valid(in_valid), .in_ready(in_ready),
    .dp_coef_we(dp_coef_we), .dp_coef_addr(dp_coef_addr), .dp_coef_data(dp_coef_data),
    .dp_shift_en(dp_shift_en), .dp_flush(dp_flush), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    bit exp_v, exp_l;
    exp_v = 1'b0;
    exp_l = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_v = 1'b1;
      exp_l = sb[0].last;
      void'(sb.pop_front());
    end
    n_total++;
    if (out_valid !== exp_v) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
    else n_pass++;
    n_total++;
    if (out_last !== exp_l) $display("FAIL out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_l);
    else n_pass++;
    n_total++;
    if (done !== exp_l) $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_l);
    else n_pass++;
    if (out_valid === 1'b1) n_out++;
  end

  task automatic idle_inputs();
    cfg_start = 1'b0; cfg_frame_len = '0; cfg_abort = 1'b0;
    coef_valid = 1'b0; coef_data = '0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cfg_start = 1'($urandom_range(0, 1)); cfg_frame_len = FL'($urandom);
      cfg_abort = 1'($urandom_range(0, 1)); coef_valid = 1'($urandom_range(0, 1));
      coef_data = DS'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if ({coef_ready, in_ready, dp_coef_we, dp_coef_addr, dp_coef_data, dp_shift_en,
           dp_flush, out_valid, out_last, busy, done} !== '0)
        $display("FAIL reset_outputs got=%b%b%b %h %h %b%b%b%b%b%b exp=all zero", coef_ready,
                 in_ready, dp_coef_we, dp_coef_addr, dp_coef_data, dp_shift_en, dp_flush,
                 out_valid, out_last, busy, done);
      else n_pass++;
    end
    @(posedge clk); #1;
    idle_inputs();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL idle_after_reset busy got=%b exp=0", busy);
      else n_pass++;
    end
  endtask

  // abort_at: sample index whose accept cycle asserts cfg_abort (-1 none).
  // reset_at: FLUSH cycle in which reset_n drops between edges (-1 none).
  task automatic run_frame(input int len, input bit gap_coef, input bit gap_in,
                           input int abort_at, input int reset_at, input bit start_in_run);
    int k, s, guard;
    bit toggle;
    n_out = 0;
    toggle = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    cfg_start = 1'b1; cfg_frame_len = FL'(len);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL start_idle busy got=%b exp=0", busy);
    else n_pass++;

    k = 0; guard = 0;
    while (k < W && guard < 200) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
      toggle = ~toggle;
      coef_valid = gap_coef ? toggle : 1'b1;
      coef_data = DS'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      n_total++;
      if ({coef_ready, busy, dp_shift_en, dp_coef_we} !== {3'b110, coef_valid})
        $display("FAIL load_ctrl k=%0d got=%b exp=%b", k,
                 {coef_ready, busy, dp_shift_en, dp_coef_we}, {3'b110, coef_valid});
      else n_pass++;
      if (coef_valid) begin
        n_total++;
        if (dp_coef_addr !== AW'(k) || dp_coef_data !== coef_data)
          $display("FAIL coef_write got=%0d/%h exp=%0d/%h", dp_coef_addr, dp_coef_data, k, coef_data);
        else n_pass++;
        k++;
      end
      guard++;
    end

    s = 0;
    while (s < len && guard < 400) begin
      @(posedge clk); #1;
      toggle = ~toggle;
      coef_valid = 1'b1;
      in_valid = gap_in ? toggle : 1'b1;
      cfg_start = start_in_run; cfg_frame_len = 16'd7;
      cfg_abort = in_valid && (s == abort_at);
      @(negedge clk);
      n_total++;
      if ({in_ready, coef_ready, dp_coef_we, dp_flush, dp_shift_en} !== {4'b1000, in_valid})
        $display("FAIL run_ctrl s=%0d got=%b exp=%b", s,
                 {in_ready, coef_ready, dp_coef_we, dp_flush, dp_shift_en}, {4'b1000, in_valid});
      else n_pass++;
      if (in_valid) begin
        sb.push_back('{due: cyc + LAT, last: 1'b0});
        s++;
      end
      guard++;
      if (cfg_abort) begin
        @(posedge clk); #1;
        idle_inputs();
        sb.delete();
        @(negedge clk);
        n_total++;
        if ({busy, in_ready} !== 2'b00) $display("FAIL abort_idle got=%b exp=00", {busy, in_ready});
        else n_pass++;
        repeat (10) @(negedge clk);
        return;
      end
    end
    n_total++;
    if (guard >= 400) $display("FAIL stim_budget got=%0d exp<400", guard);
    else n_pass++;

    for (int i = 0; i < int'(W) - 1; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      in_valid = 1'b1;
      if (i == reset_at) begin
        #3;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({coef_ready, in_ready, dp_coef_we, dp_shift_en, dp_flush, out_valid, out_last,
             busy, done} !== '0)
          $display("FAIL async_reset got=%b exp=0", {coef_ready, in_ready, dp_coef_we,
                   dp_shift_en, dp_flush, out_valid, out_last, busy, done});
        else n_pass++;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        reset_n = 1'b1;
        return;
      end
      @(negedge clk);
      n_total++;
      if ({dp_shift_en, dp_flush, in_ready, busy} !== 4'b1101)
        $display("FAIL flush_ctrl i=%0d got=%b exp=1101", i, {dp_shift_en, dp_flush, in_ready, busy});
      else n_pass++;
      sb.push_back('{due: cyc + LAT, last: (i == int'(W) - 2)});
    end

    @(posedge clk); #1;
    idle_inputs();
    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      @(negedge clk); #1;
      if (sb.size() > 0) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL drain_busy got=%b exp=1", busy);
        else n_pass++;
      end
      guard++;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL busy_after_done got=%b exp=0", busy);
    else n_pass++;
    n_total++;
    if (n_out != len + W - 1) $display("FAIL out_count got=%0d exp=%0d", n_out, len + W - 1);
    else n_pass++;
  endtask

  task automatic test_nominal();
    run_frame(4, 1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_gapped();
    run_frame(4, 1'b1, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      cfg_start = 1'b1; cfg_frame_len = '0;
      @(negedge clk);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL len_zero busy got=%b exp=0", busy);
      else n_pass++;
    end
    run_frame(5, 1'b0, 1'b1, -1, -1, 1'b1);
  endtask

  task automatic test_abort();
    run_frame(4, 1'b0, 1'b0, 1, -1, 1'b0);
    run_frame(1, 1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_async_reset();
    run_frame(4, 1'b0, 1'b0, -1, 5, 1'b0);
    run_frame(3, 1'b1, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_ignored();
    test_abort();
    test_async_reset();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d cycles exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
